param_sp_mem: RTL and testbench

- Parametrised single-port synchronous memory; next generation of the 16x32 memory DUT.
- Generalised in data width, depth and read latency; adds byte-write enables, post-reset clear sweep with ready flag, and out-of-range address error.
- Driven and monitored by the team's UVM memory environment; request semantics (en/re/addr/data_in, data_out/valid_out) are unchanged.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_rd_pipe.sv | 56 +++++
 rtl/param_sp_mem.sv | 120 ++++++++++++
 tb/tb_param_sp_mem.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised single-port memory.
// The FSM state encoding, per-byte parity helper and pipeline limits live here.
package mem_pkg;

  localparam int RD_LAT_MAX = 4;
  localparam int BYTE_W     = 8;

  typedef enum logic [0:0] {
    MEM_INIT = 1'b0,
    MEM_RUN  = 1'b1
  } mem_state_e;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response delay line: RD_LAT register stages carrying {valid, addr_err, par_err, data}.
// The data field only advances with a valid response, so the last stage holds the last read value.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_addr_err,
  input  logic              in_par_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_addr_err,
  output logic              out_par_err,
  output logic [DATA_W-1:0] out_data
);

  typedef struct packed {
    logic              valid;
    logic              addr_err;
    logic              par_err;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t              stg_in;
  stage_t [RD_LAT-1:0] pipe_q;

  assign stg_in = {in_valid, in_addr_err, in_par_err, in_data};

  function automatic stage_t advance(input stage_t src, input stage_t cur);
    stage_t nxt;
    nxt = src;
    if (!src.valid) nxt.data = cur.data;
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= advance(stg_in, pipe_q[0]);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= advance(pipe_q[i-1], pipe_q[i]);
      end
    end
  end

  assign out_valid    = pipe_q[RD_LAT-1].valid;
  assign out_addr_err = pipe_q[RD_LAT-1].addr_err;
  assign out_par_err  = pipe_q[RD_LAT-1].par_err;
  assign out_data     = pipe_q[RD_LAT-1].data;

endmodule

// File: rtl/param_sp_mem.sv
// Parametrised single-port synchronous memory with byte enables, post-reset clear sweep,
// out-of-range error and optional per-byte parity (enabled by defining MEM_PARITY_EN).
module param_sp_mem
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     data_out,
  output logic                  valid_out,
  output logic                  addr_err,
  output logic                  ready,
  output logic                  par_err
);

  localparam int                NB        = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  mem_state_e        state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              ready_q;

  logic              in_range;
  logic              acc;
  logic              wr_hit;
  logic              rd_hit;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic              rd_par_err;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Clear sweep: one word per cycle, then RUN; ready follows RUN by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MEM_INIT;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= (state_q == MEM_RUN);
      case (state_q)
        MEM_INIT: begin
          if (clr_ptr_q == LAST_ADDR) state_q <= MEM_RUN;
          else                        clr_ptr_q <= clr_ptr_q + 1'b1;
        end
        default: state_q <= MEM_RUN;
      endcase
    end
  end

  assign ready    = ready_q;
  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign acc      = ready_q & en;
  assign wr_hit   = acc & ~re & in_range;
  assign rd_hit   = acc & re & in_range;
  assign rd_addr  = in_range ? addr : '0;
  assign rd_word  = mem_q[rd_addr];

  always_ff @(posedge clk) begin
    if (state_q == MEM_INIT) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[addr][i*BYTE_W +: BYTE_W] <= data_in[i*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];

  // The clear sweep stores parity of an all-zero byte, which is 0.
  always_ff @(posedge clk) begin
    if (state_q == MEM_INIT) begin
      par_q[clr_ptr_q] <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) par_q[addr][i] <= byte_parity(data_in[i*BYTE_W +: BYTE_W]);
      end
    end
  end

  always_comb begin
    rd_par_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (byte_parity(rd_word[i*BYTE_W +: BYTE_W]) != par_q[rd_addr][i]) rd_par_err = 1'b1;
    end
  end
`else
  assign rd_par_err = 1'b0;
`endif

  // Out-of-range reads still produce a (zero) response so the requester never stalls.
  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (acc & re),
    .in_addr_err  (acc & ~in_range),
    .in_par_err   (rd_hit & rd_par_err),
    .in_data      (rd_hit ? rd_word : '0),
    .out_valid    (valid_out),
    .out_addr_err (addr_err),
    .out_par_err  (par_err),
    .out_data     (data_out)
  );

endmodule

// File: tb/tb_param_sp_mem.sv
// Directed bench for param_sp_mem: three instances cover RD_LAT=1/DEPTH=16,
// RD_LAT=3/DEPTH=12 and RD_LAT=2/DEPTH=16 (reset during an in-flight read).
module tb_param_sp_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [3];
  logic        en        [3];
  logic        re        [3];
  logic [3:0]  addr      [3];
  logic [31:0] data_in   [3];
  logic [3:0]  be        [3];
  logic [31:0] data_out  [3];
  logic        valid_out [3];
  logic        addr_err  [3];
  logic        ready     [3];
  logic        par_err   [3];

  int n_vec = 0;
  int n_bad = 0;

  param_sp_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst[0]), .en(en[0]), .re(re[0]), .addr(addr[0]), .data_in(data_in[0]),
    .be(be[0]), .data_out(data_out[0]), .valid_out(valid_out[0]), .addr_err(addr_err[0]),
    .ready(ready[0]), .par_err(par_err[0]));

  param_sp_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_LAT(3)) u_b (
    .clk(clk), .rst(rst[1]), .en(en[1]), .re(re[1]), .addr(addr[1]), .data_in(data_in[1]),
    .be(be[1]), .data_out(data_out[1]), .valid_out(valid_out[1]), .addr_err(addr_err[1]),
    .ready(ready[1]), .par_err(par_err[1]));

  param_sp_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(2)) u_c (
    .clk(clk), .rst(rst[2]), .en(en[2]), .re(re[2]), .addr(addr[2]), .data_in(data_in[2]),
    .be(be[2]), .data_out(data_out[2]), .valid_out(valid_out[2]), .addr_err(addr_err[2]),
    .ready(ready[2]), .par_err(par_err[2]));

  typedef struct {
    logic        en;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic req(input int d, input logic e, input logic r, input logic [3:0] a,
                     input logic [31:0] dt, input logic [3:0] b);
    en[d] = e; re[d] = r; addr[d] = a; data_in[d] = dt; be[d] = b;
  endtask

  task automatic idle(input int d);
    req(d, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic chk_out(input string name, input int d, input logic v,
                         input logic [31:0] dat, input logic err);
    chk({name, " valid"},    32'(valid_out[d]), 32'(v));
    chk({name, " data"},     data_out[d],       dat);
    chk({name, " addr_err"}, 32'(addr_err[d]),  32'(err));
    chk({name, " par_err"},  32'(par_err[d]),   32'h0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0;
      idle(d);
    end

    vecs[0]  = '{1'b1, 1'b0, 4'd3,  32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 4'd3,  32'h11223344, 4'h5, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b1, 1'b1, 4'd3,  32'h0,        4'h0, 1'b1, 32'hDE22BE44};
    vecs[3]  = '{1'b1, 1'b0, 4'd5,  32'hCAFEF00D, 4'hF, 1'b0, 32'hDE22BE44};
    vecs[4]  = '{1'b1, 1'b1, 4'd5,  32'h0,        4'h0, 1'b1, 32'hCAFEF00D};
    vecs[5]  = '{1'b1, 1'b0, 4'd7,  32'h12345678, 4'h0, 1'b0, 32'hCAFEF00D};
    vecs[6]  = '{1'b1, 1'b1, 4'd7,  32'h0,        4'h0, 1'b1, 32'h00000000};
    vecs[7]  = '{1'b0, 1'b1, 4'd5,  32'h0,        4'h0, 1'b0, 32'h00000000};
    vecs[8]  = '{1'b1, 1'b0, 4'd7,  32'hAABBCCDD, 4'h8, 1'b0, 32'h00000000};
    vecs[9]  = '{1'b1, 1'b1, 4'd7,  32'h0,        4'h0, 1'b1, 32'hAA000000};
    vecs[10] = '{1'b1, 1'b0, 4'd15, 32'hFFFFFFFF, 4'hF, 1'b0, 32'hAA000000};
    vecs[11] = '{1'b1, 1'b1, 4'd15, 32'h0,        4'h0, 1'b1, 32'hFFFFFFFF};
    vecs[12] = '{1'b1, 1'b1, 4'd3,  32'h0,        4'h0, 1'b1, 32'hDE22BE44};
    vecs[13] = '{1'b1, 1'b1, 4'd0,  32'h0,        4'h0, 1'b1, 32'h00000000};
    vecs[14] = '{1'b1, 1'b1, 4'd2,  32'h0,        4'h0, 1'b1, 32'h00000000};
    vecs[15] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'h0, 1'b0, 32'h00000000};

    // Reset values
    tick();
    for (int d = 0; d < 3; d++) begin
      chk_out("reset", d, 1'b0, 32'h0, 1'b0);
      chk("reset ready", 32'(ready[d]), 32'h0);
    end

    // Release reset; requests during the sweep must be ignored
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;
    req(0, 1'b1, 1'b0, 4'd2, 32'hFFFFFFFF, 4'hF);
    req(1, 1'b1, 1'b1, 4'd13, 32'h0, 4'h0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      chk($sformatf("init a ready e%0d", n), 32'(ready[0]), 32'(n == 17));
      chk($sformatf("init b ready e%0d", n), 32'(ready[1]), 32'(n >= 13));
      chk($sformatf("init c ready e%0d", n), 32'(ready[2]), 32'(n == 17));
      chk_out($sformatf("init a e%0d", n), 0, 1'b0, 32'h0, 1'b0);
      chk_out($sformatf("init b e%0d", n), 1, 1'b0, 32'h0, 1'b0);
      if (n == 12) idle(1);
    end
    idle(0);

    // Every word reads back zero after the sweep
    for (int a = 0; a < 16; a++) begin
      req(0, 1'b1, 1'b1, 4'(a), 32'h0, 4'h0);
      tick();
      chk_out($sformatf("sweep a%0d", a), 0, 1'b1, 32'h0, 1'b0);
    end

    // Table vectors on the RD_LAT=1 instance
    for (int i = 0; i < 16; i++) begin
      req(0, vecs[i].en, vecs[i].re, vecs[i].addr, vecs[i].data, vecs[i].be);
      tick();
      chk_out($sformatf("vec%0d", i), 0, vecs[i].exp_v, vecs[i].exp_d, 1'b0);
    end
    idle(0);

    // RD_LAT=3: preload, then three pipelined reads
    for (int a = 0; a < 3; a++) begin
      req(1, 1'b1, 1'b0, 4'(a), 32'hA0 + 32'(a), 4'hF);
      tick();
    end
    req(1, 1'b1, 1'b1, 4'd0, 32'h0, 4'h0); tick(); chk_out("pipe k",   1, 1'b0, 32'h0,  1'b0);
    req(1, 1'b1, 1'b1, 4'd1, 32'h0, 4'h0); tick(); chk_out("pipe k+1", 1, 1'b0, 32'h0,  1'b0);
    req(1, 1'b1, 1'b1, 4'd2, 32'h0, 4'h0); tick(); chk_out("pipe k+2", 1, 1'b1, 32'hA0, 1'b0);
    idle(1);                               tick(); chk_out("pipe k+3", 1, 1'b1, 32'hA1, 1'b0);
    tick(); chk_out("pipe k+4", 1, 1'b1, 32'hA2, 1'b0);
    tick(); chk_out("pipe k+5", 1, 1'b0, 32'hA2, 1'b0);

    // DEPTH=12: out-of-range write and read
    req(1, 1'b1, 1'b0, 4'd13, 32'h55, 4'hF); tick(); chk_out("oor wr k", 1, 1'b0, 32'hA2, 1'b0);
    idle(1); tick(); chk_out("oor wr k+1", 1, 1'b0, 32'hA2, 1'b0);
    tick(); chk_out("oor wr k+2", 1, 1'b0, 32'hA2, 1'b1);
    tick(); chk_out("oor wr k+3", 1, 1'b0, 32'hA2, 1'b0);
    req(1, 1'b1, 1'b1, 4'd13, 32'h0, 4'h0); tick(); chk_out("oor rd k", 1, 1'b0, 32'hA2, 1'b0);
    idle(1); tick(); chk_out("oor rd k+1", 1, 1'b0, 32'hA2, 1'b0);
    tick(); chk_out("oor rd k+2", 1, 1'b1, 32'h0, 1'b1);
    tick(); chk_out("oor rd k+3", 1, 1'b0, 32'h0, 1'b0);
    for (int a = 0; a < 12; a++) begin
      req(1, 1'b1, 1'b1, 4'(a), 32'h0, 4'h0);
      tick();
      idle(1);
      tick();
      tick();
      chk_out($sformatf("intact b%0d", a), 1, 1'b1, (a < 3) ? 32'hA0 + 32'(a) : 32'h0, 1'b0);
    end

    // RD_LAT=2: write-then-read, then reset with a read in flight
    req(2, 1'b1, 1'b0, 4'd4, 32'h00001234, 4'hF); tick();
    req(2, 1'b1, 1'b1, 4'd4, 32'h0, 4'h0); tick(); chk_out("c rd k", 2, 1'b0, 32'h0, 1'b0);
    idle(2); tick(); chk_out("c rd k+1", 2, 1'b1, 32'h00001234, 1'b0);
    req(2, 1'b1, 1'b1, 4'd4, 32'h0, 4'h0); tick();
    rst[2] = 1'b0;
    idle(2);
    #1;
    chk_out("c async rst", 2, 1'b0, 32'h0, 1'b0);
    chk("c async rst ready", 32'(ready[2]), 32'h0);
    tick(); chk_out("c rst k+1", 2, 1'b0, 32'h0, 1'b0);
    tick();
    rst[2] = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      tick();
      chk($sformatf("reinit c ready e%0d", n), 32'(ready[2]), 32'(n == 17));
      chk_out($sformatf("reinit c e%0d", n), 2, 1'b0, 32'h0, 1'b0);
    end
    req(2, 1'b1, 1'b1, 4'd4, 32'h0, 4'h0); tick(); chk_out("c cleared k", 2, 1'b0, 32'h0, 1'b0);
    idle(2); tick(); chk_out("c cleared k+1", 2, 1'b1, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
